aes_host_queue: RTL and testbench

Parametrised byte-bus host interface for the AES ASIC. It is the next generation of the single-shot IO interface. It assembles plaintext, key and mode from 8-bit register writes. It snapshots each START into a job issued to the encrypt/decrypt core over a valid/ready handshake, with a credit limit. Returned blocks are buffered in a DEPTH-entry result FIFO that the host reads byte-wise. It sits between the chip pins (DIN/ADDR/WR/START/OK/DOUT) and the core/key-expansion pair.

---
 rtl/aes_host_pkg.sv | 31 +++
 rtl/aes_res_fifo.sv | 65 ++++++
 rtl/aes_host_queue.sv | 199 +++++++++++++++++++
 tb/tb_aes_host_queue.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_host_pkg.sv
// Shared definitions for the AES host queue: register map, key-size
// encoding and the key-size to Nk/Nr decode.
package aes_host_pkg;

  // Byte address map (7-bit ADDR).
  localparam logic [6:0] PT_BASE  = 7'h00;
  localparam logic [6:0] KEY_BASE = 7'h10;
  localparam logic [6:0] CTRL     = 7'h30;
  localparam logic [6:0] RES_BASE = 7'h40;
  localparam logic [6:0] STAT     = 7'h50;
  localparam logic [6:0] CMD      = 7'h51;

  // Control register key-size field; the unused code 2'b11 decodes as 128.
  typedef enum logic [1:0] {
    KS_128 = 2'b00,
    KS_192 = 2'b01,
    KS_256 = 2'b10
  } key_size_e;

  // Returns {nk, nr}: key length in 32-bit words and round count.
  function automatic logic [7:0] decode_nk_nr(input logic [1:0] ks);
    logic [7:0] r;
    case (ks)
      KS_192:  r = {4'd6, 4'd12};
      KS_256:  r = {4'd8, 4'd14};
      default: r = {4'd4, 4'd10};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_res_fifo.sv
// Result buffer: circular FIFO with wrap-around pointers and an occupancy
// count. Push into a full FIFO and pop from an empty one are ignored.
module aes_res_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [3:0]       count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = count_q;
  assign full    = (count_q == 4'(DEPTH));
  assign empty   = (count_q == 4'd0);

  // Storage and pointers; pointers wrap from DEPTH-1 back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/aes_host_queue.sv
// Byte-bus host interface for the AES core. Staging registers collect
// plaintext/key/control from byte writes; a START rising edge snapshots them
// into a job offered to the core; returned blocks queue in a result FIFO that
// the host reads byte-wise. Outstanding jobs plus stored results never exceed
// DEPTH, so a returned block always finds room.
//
// Handshakes: a transfer happens on a clock edge where valid & ready are both
// high. The sender holds valid and its payload stable until that edge; the
// receiver may change ready freely. job_valid/job_ready carry jobs to the
// core, res_valid/res_ready carry results back.
module aes_host_queue
  import aes_host_pkg::*;
#(
  parameter int BLK_W = 128,
  parameter int KEY_W = 256,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic [7:0]       DIN,
  input  logic [6:0]       ADDR,
  input  logic             WR,
  input  logic             START,
  output logic             OK,
  output logic [7:0]       DOUT,
  output logic             job_valid,
  input  logic             job_ready,
  output logic [BLK_W-1:0] blk_out,
  output logic [KEY_W-1:0] key_out,
  output logic [3:0]       nk,
  output logic [3:0]       nr,
  output logic             op,
  input  logic             res_valid,
  input  logic [BLK_W-1:0] res_data,
  output logic             res_ready
);

  localparam int PT_BYTES  = BLK_W / 8;
  localparam int KEY_BYTES = KEY_W / 8;
  localparam int PT_IW     = $clog2(PT_BYTES);
  localparam int KEY_IW    = $clog2(KEY_BYTES);

  // Staging registers, byte-addressed; byte 0 is the most significant.
  logic [7:0]       pt_b  [PT_BYTES];
  logic [7:0]       key_b [KEY_BYTES];
  logic [1:0]       ks_q;
  logic             op_q;
  logic [BLK_W-1:0] pt_vec;
  logic [KEY_W-1:0] key_vec;

  // Job registers presented to the core.
  logic [BLK_W-1:0] job_blk_q;
  logic [KEY_W-1:0] job_key_q;
  logic [1:0]       job_ks_q;
  logic             job_op_q;
  logic             job_valid_q;

  logic             start_q;
  logic             err_q;
  logic [3:0]       inflight_q;

  // Result FIFO view.
  logic [BLK_W-1:0] head;
  logic [7:0]       head_b [PT_BYTES];
  logic [3:0]       count;
  logic             full;
  logic             empty;

  logic wr_pt, wr_key, wr_ctrl, wr_cmd;
  logic start_edge, credit_ok, accept;
  logic job_xfer, res_push, res_pop;
  logic [7:0] rd_data;

  genvar g;
  generate
    for (g = 0; g < PT_BYTES; g++) begin : g_pt_bytes
      assign pt_vec[BLK_W-1-8*g -: 8] = pt_b[g];
      assign head_b[g]                = head[BLK_W-1-8*g -: 8];
    end
    for (g = 0; g < KEY_BYTES; g++) begin : g_key_bytes
      assign key_vec[KEY_W-1-8*g -: 8] = key_b[g];
    end
  endgenerate

  assign wr_pt   = WR & (ADDR < KEY_BASE);
  assign wr_key  = WR & (ADDR >= KEY_BASE) & (ADDR < CTRL);
  assign wr_ctrl = WR & (ADDR == CTRL);
  assign wr_cmd  = WR & (ADDR == CMD);

  // Credit check uses pre-update inflight and count.
  assign start_edge = START & ~start_q;
  assign credit_ok  = ({1'b0, inflight_q} + {1'b0, count}) < 5'(DEPTH);
  assign accept     = start_edge & ~job_valid_q & credit_ok;
  assign job_xfer   = job_valid_q & job_ready;
  assign res_push   = res_valid & ~full;
  assign res_pop    = wr_cmd & DIN[0] & ~empty;

  // Host writes into the staging registers.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      pt_b  <= '{default: 8'h00};
      key_b <= '{default: 8'h00};
      ks_q  <= 2'b00;
      op_q  <= 1'b0;
    end else begin
      if (wr_pt)  pt_b[PT_IW'(ADDR - PT_BASE)]    <= DIN;
      if (wr_key) key_b[KEY_IW'(ADDR - KEY_BASE)] <= DIN;
      if (wr_ctrl) begin
        ks_q <= DIN[1:0];
        op_q <= DIN[2];
      end
    end
  end

  // Job snapshot on accepted START edge; cleared by the core handshake.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      job_blk_q   <= '0;
      job_key_q   <= '0;
      job_ks_q    <= 2'b00;
      job_op_q    <= 1'b0;
      job_valid_q <= 1'b0;
    end else if (accept) begin
      job_blk_q   <= pt_vec;
      job_key_q   <= key_vec;
      job_ks_q    <= ks_q;
      job_op_q    <= op_q;
      job_valid_q <= 1'b1;
    end else if (job_xfer) begin
      job_valid_q <= 1'b0;
    end
  end

  // START edge detect and sticky error; a new rejected edge wins over a clear.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= START;
      if (start_edge & ~accept)
        err_q <= 1'b1;
      else if (wr_cmd & DIN[7])
        err_q <= 1'b0;
    end
  end

  // Jobs held by the core: up on job transfer, down on result push.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      inflight_q <= 4'd0;
    end else begin
      case ({job_xfer, res_push})
        2'b10:   inflight_q <= inflight_q + 4'd1;
        2'b01:   inflight_q <= inflight_q - 4'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  aes_res_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk       (CLK),
    .rst_n     (RSTB),
    .push      (res_push),
    .push_data (res_data),
    .pop       (res_pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Read mux: FIFO head bytes, status, or zero.
  always_comb begin
    rd_data = 8'h00;
    if ((ADDR >= RES_BASE) && (ADDR < STAT))
      rd_data = empty ? 8'h00 : head_b[PT_IW'(ADDR - RES_BASE)];
    else if (ADDR == STAT)
      rd_data = {err_q, job_valid_q, count, full, empty};
  end

  // Registered read data: one cycle behind ADDR.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) DOUT <= 8'h00;
    else       DOUT <= rd_data;
  end

  assign OK        = ~empty;
  assign res_ready = ~full;
  assign job_valid = job_valid_q;
  assign blk_out   = job_blk_q;
  assign key_out   = job_key_q;
  assign op        = job_op_q;
  assign {nk, nr}  = decode_nk_nr(job_ks_q);

endmodule

// File: tb/tb_aes_host_queue.sv
// Bench for aes_host_queue: directed register-map scenarios followed by
// random host/core traffic, checked every cycle against a byte-array and
// queue model of the host interface.
module tb_aes_host_queue;

  localparam int BLK_W = 128;
  localparam int KEY_W = 256;
  localparam int DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic             CLK = 1'b0;
  logic             RSTB = 1'b1;
  logic [7:0]       DIN = '0;
  logic [6:0]       ADDR = '0;
  logic             WR = 1'b0;
  logic             START = 1'b0;
  logic             OK;
  logic [7:0]       DOUT;
  logic             job_valid;
  logic             job_ready = 1'b0;
  logic [BLK_W-1:0] blk_out;
  logic [KEY_W-1:0] key_out;
  logic [3:0]       nk;
  logic [3:0]       nr;
  logic             op;
  logic             res_valid = 1'b0;
  logic [BLK_W-1:0] res_data = '0;
  logic             res_ready;

  always #5 CLK = ~CLK;

  aes_host_queue #(.BLK_W(BLK_W), .KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTB(RSTB), .DIN(DIN), .ADDR(ADDR), .WR(WR), .START(START),
    .OK(OK), .DOUT(DOUT), .job_valid(job_valid), .job_ready(job_ready),
    .blk_out(blk_out), .key_out(key_out), .nk(nk), .nr(nr), .op(op),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [KEY_W-1:0] act,
                       input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]       pt_m  [16];
  logic [7:0]       key_m [32];
  logic [2:0]       ctrl_m;
  logic             start_prev;
  logic             job_pend;
  logic [BLK_W-1:0] job_blk_m;
  logic [KEY_W-1:0] job_key_m;
  logic [2:0]       job_ctrl_m;
  int               inflight_m;
  logic             err_m;
  logic [7:0]       dout_m;
  logic [BLK_W-1:0] exp_q[$];

  function automatic logic [BLK_W-1:0] pack_pt();
    logic [BLK_W-1:0] v;
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = pt_m[i];
    return v;
  endfunction

  function automatic logic [KEY_W-1:0] pack_key();
    logic [KEY_W-1:0] v;
    for (int i = 0; i < 32; i++) v[255-8*i -: 8] = key_m[i];
    return v;
  endfunction

  // Key-size table: 192 -> 6 words/12 rounds, 256 -> 8/14, else 4/10.
  function automatic logic [7:0] exp_nk_nr(input logic [1:0] ks);
    if (ks == 2'd1) return {4'd6, 4'd12};
    if (ks == 2'd2) return {4'd8, 4'd14};
    return {4'd4, 4'd10};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pt_m[i] = 8'h00;
    for (int i = 0; i < 32; i++) key_m[i] = 8'h00;
    ctrl_m = 3'd0; start_prev = 1'b0; job_pend = 1'b0;
    job_blk_m = '0; job_key_m = '0; job_ctrl_m = 3'd0;
    inflight_m = 0; err_m = 1'b0; dout_m = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_step();
    int               sz;
    int               off;
    logic             acc, xfer, push, pop, start_rise;
    logic [7:0]       dnext;
    logic [BLK_W-1:0] h;
    sz         = exp_q.size();
    start_rise = START && !start_prev;
    acc        = start_rise && !job_pend && (inflight_m + sz < DEPTH);
    xfer       = job_pend && job_ready;
    push       = res_valid && (sz < DEPTH);
    pop        = WR && (ADDR == 7'h51) && DIN[0] && (sz > 0);
    dnext      = 8'h00;
    if (ADDR >= 7'h40 && ADDR <= 7'h4F) begin
      if (sz > 0) begin
        h     = exp_q[0];
        off   = int'(ADDR) - 64;
        dnext = h[127-8*off -: 8];
      end
    end else if (ADDR == 7'h50) begin
      dnext = {err_m, job_pend, 4'(sz), (sz == DEPTH), (sz == 0)};
    end
    if (acc) begin
      job_blk_m = pack_pt(); job_key_m = pack_key(); job_ctrl_m = ctrl_m;
      job_pend = 1'b1;
    end else if (xfer) begin
      job_pend = 1'b0;
    end
    if (xfer) inflight_m++;
    if (push) inflight_m--;
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(res_data);
    if (start_rise && !acc) err_m = 1'b1;
    else if (WR && ADDR == 7'h51 && DIN[7]) err_m = 1'b0;
    if (WR) begin
      if (ADDR < 7'h10)      pt_m[int'(ADDR)] = DIN;
      else if (ADDR < 7'h30) key_m[int'(ADDR) - 16] = DIN;
      else if (ADDR == 7'h30) ctrl_m = DIN[2:0];
    end
    start_prev = START;
    dout_m     = dnext;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RSTB);
      if (!RSTB) model_reset();
      else       model_step();
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge CLK);
      check("ok", OK, exp_q.size() > 0);
      check("res_ready", res_ready, exp_q.size() < DEPTH);
      check("dout", DOUT, dout_m);
      check("job_valid", job_valid, job_pend);
      check("blk_out", blk_out, job_blk_m);
      check("key_out", key_out, job_key_m);
      check("nk_nr", {nk, nr}, exp_nk_nr(job_ctrl_m[1:0]));
      check("op", op, job_ctrl_m[2]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    WR = 1'b0; START = 1'b0; job_ready = 1'b0; res_valid = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    WR = 1'b1; ADDR = a; DIN = d;
    @(negedge CLK);
    WR = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a, input logic [7:0] e);
    ADDR = a;
    @(negedge CLK);
    check(name, DOUT, e);
  endtask

  task automatic start_pulse();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic take_job();
    job_ready = 1'b1;
    @(negedge CLK);
    job_ready = 1'b0;
  endtask

  task automatic push_res(input logic [BLK_W-1:0] d);
    res_valid = 1'b1; res_data = d;
    @(negedge CLK);
    res_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [BLK_W-1:0] pt_v;
  logic [BLK_W-1:0] rres [4];
  int               rsel;

  initial begin
    pt_v = 128'h00112233445566778899aabbccddeeff;
    #1 RSTB = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ok", OK, 1'b0);
    check("rst_dout", DOUT, 8'h00);
    check("rst_job_valid", job_valid, 1'b0);
    check("rst_nk", nk, 4'd4);
    check("rst_nr", nr, 4'd10);
    check("rst_res_ready", res_ready, 1'b1);
    RSTB = 1'b1;
    rd_chk("rst_status", 7'h50, 8'h01);

    // Load plaintext, key bytes 00..0f, ctrl 0 and start a job.
    for (int i = 0; i < 16; i++) wr(7'(i), pt_v[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) wr(7'(16 + i), 8'(i));
    wr(7'h30, 8'h00);
    start_pulse();
    check("job_valid_set", job_valid, 1'b1);
    check("blk_lit", blk_out, 128'h00112233445566778899aabbccddeeff);
    check("key_hi_lit", key_out[255:128], 128'h000102030405060708090a0b0c0d0e0f);
    check("nk_lit", nk, 4'd4);
    check("nr_lit", nr, 4'd10);
    check("op_lit", op, 1'b0);
    take_job();
    check("job_valid_clr", job_valid, 1'b0);

    // Result return and byte-wise read-back.
    push_res(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("ok_after_push", OK, 1'b1);
    rd_chk("res_byte0", 7'h40, 8'h69);
    rd_chk("res_byte15", 7'h4F, 8'h5a);
    wr(7'h51, 8'h01);
    check("ok_after_pop", OK, 1'b0);

    // Credit limit: DEPTH jobs outstanding, next START is rejected.
    for (int k = 0; k < DEPTH; k++) begin
      start_pulse();
      take_job();
    end
    start_pulse();
    check("credit_reject", job_valid, 1'b0);
    rd_chk("err_status", 7'h50, 8'h81);
    wr(7'h51, 8'h80);
    rd_chk("err_cleared", 7'h50, 8'h01);

    // Return all results: FIFO full.
    for (int k = 0; k < 4; k++) begin
      rres[k] = {$urandom, $urandom, $urandom, $urandom};
      push_res(rres[k]);
    end
    rd_chk("full_status", 7'h50, 8'h12);
    check("full_res_ready", res_ready, 1'b0);
    wr(7'h51, 8'h01);
    wr(7'h51, 8'h01);

    // 256-bit decrypt job with two results still stored.
    wr(7'h30, 8'h06);
    start_pulse();
    check("nk_256", nk, 4'd8);
    check("nr_256", nr, 4'd14);
    check("op_dec", op, 1'b1);
    take_job();

    // Push and pop in the same cycle at count 2.
    WR = 1'b1; ADDR = 7'h51; DIN = 8'h01;
    res_valid = 1'b1; res_data = {4{32'hcafef00d}};
    @(negedge CLK);
    WR = 1'b0; res_valid = 1'b0;
    rd_chk("pushpop_status", 7'h50, 8'h08);
    rd_chk("pushpop_order", 7'h40, rres[3][127:120]);

    // Reserved key-size code decodes as 128.
    wr(7'h30, 8'h03);
    start_pulse();
    check("nk_11", nk, 4'd4);
    check("nr_11", nr, 4'd10);

    // Asynchronous reset with a job pending and results stored.
    #2 RSTB = 1'b0;
    #1;
    check("arst_job_valid", job_valid, 1'b0);
    check("arst_ok", OK, 1'b0);
    check("arst_blk", blk_out, '0);
    check("arst_res_ready", res_ready, 1'b1);
    @(negedge CLK);
    RSTB = 1'b1;
    rd_chk("arst_status", 7'h50, 8'h01);

    // Random host and core traffic.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        idle_inputs();
        RSTB = 1'b0;
        repeat (2) @(negedge CLK);
        RSTB = 1'b1;
      end
      rsel = $urandom_range(0, 9);
      case (rsel)
        0, 1, 2: ADDR = 7'($urandom_range(0, 47));
        3:       ADDR = 7'h30;
        4:       ADDR = 7'h51;
        5, 6, 7: ADDR = 7'($urandom_range(64, 79));
        8:       ADDR = 7'h50;
        default: ADDR = 7'($urandom_range(0, 127));
      endcase
      WR        = ($urandom_range(0, 2) == 0);
      DIN       = 8'($urandom);
      START     = ($urandom_range(0, 2) == 0);
      job_ready = ($urandom_range(0, 1) == 1);
      res_valid = (inflight_m > 0) && ($urandom_range(0, 2) != 0);
      res_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
    end
    idle_inputs();
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
